// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : Restoring shift-and-subtract divider, one quotient bit per clock.
//            Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands.
// Revision : 1.0
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              c_CW         = $clog2(WIDTH + 1);
  localparam logic [1:0]      c_IDLE       = 2'd0;
  localparam logic [1:0]      c_RUN        = 2'd1;
  localparam logic [1:0]      c_DONE       = 2'd2;
  localparam logic [c_CW-1:0] c_COUNT_INIT = c_CW'(WIDTH);
  localparam logic [c_CW-1:0] c_COUNT_ONE  = c_CW'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [c_CW-1:0]  r_count;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic             r_dz;
  logic             r_done;

  logic             w_accept;
  logic             w_busy;
  logic             w_load_out;
  logic             w_last;
  logic             w_dsr_zero;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_sum;
  logic             w_carry;
  logic             w_unused;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (start) begin
          w_next_state = w_dsr_zero ? c_DONE : c_RUN;
        end
      end
      c_RUN: begin
        if (w_last) begin
          w_next_state = c_DONE;
        end
      end
      c_DONE:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State-decoded controls
  // ---------------------------------------------------------------------------
  always_comb begin
    w_accept   = 1'b0;
    w_busy     = 1'b0;
    w_load_out = 1'b0;
    case (r_state)
      c_IDLE:  w_accept   = start;
      c_RUN:   w_busy     = 1'b1;
      c_DONE:  w_load_out = 1'b1;
      default: w_accept   = 1'b0;
    endcase
  end

  assign busy       = w_busy;
  assign done       = r_done;
  assign w_last     = (r_count == c_COUNT_ONE);
  assign w_dsr_zero = (divisor == '0);

  // Trial subtraction as an add of the inverted (WIDTH+1)-bit divisor, carry-in 1;
  // the carry out of the top bit means no borrow.
  assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
  assign w_sum    = {1'b0, w_shift} + {2'b01, ~r_dsr} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign w_carry  = w_sum[WIDTH+1];
  assign w_unused = w_sum[WIDTH];

  // ---------------------------------------------------------------------------
  // Operand conditioning and result fix-up
  // ---------------------------------------------------------------------------
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] w_r_mag;

  assign w_dvd_mag = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
  assign w_dsr_mag = divisor[WIDTH-1]  ? ('0 - divisor)  : divisor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_r <= dividend[WIDTH-1];
    end
  end

  // On divide by zero the dividend magnitude is re-signed to recover the original
  assign w_r_mag   = r_dz ? r_dvd : r_rem;
  assign w_q_final = r_dz ? '1 : (r_neg_q ? ('0 - r_dvd) : r_dvd);
  assign w_r_final = r_neg_r ? ('0 - w_r_mag) : w_r_mag;
`else
  assign w_dvd_mag = dividend;
  assign w_dsr_mag = divisor;
  assign w_q_final = r_dz ? '1 : r_dvd;
  assign w_r_final = r_dz ? r_dvd : r_rem;
`endif

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_dsr       <= '0;
      r_dz        <= 1'b0;
      r_done      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_done <= w_load_out;
      if (w_accept) begin
        r_dvd   <= w_dvd_mag;
        r_dsr   <= w_dsr_mag;
        r_rem   <= '0;
        r_dz    <= w_dsr_zero;
        r_count <= w_dsr_zero ? '0 : c_COUNT_INIT;
      end
      if (w_busy) begin
        // Quotient bits shift into the vacated dividend positions
        r_rem   <= w_carry ? w_sum[WIDTH-1:0] : w_shift[WIDTH-1:0];
        r_dvd   <= {r_dvd[WIDTH-2:0], w_carry};
        r_count <= r_count - c_COUNT_ONE;
      end
      if (w_load_out) begin
        quotient    <= w_q_final;
        remainder   <= w_r_final;
        div_by_zero <= r_dz;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Brief    : Directed self-checking bench for seq_divider (WIDTH=4).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_seq_divider;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the design idle; m counts rising edges after the start edge
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int eq, input int er, input int edz, input int elat, input int ebusy);
    int done_m;
    int busy_n;
    int overlap;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_m  = -1;
    busy_n  = 0;
    overlap = 0;
    for (int m = 0; m < 20 && done_m < 0; m++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (busy && done) overlap++;
      if (done) done_m = m;
    end
    check({tag, "_latency"}, done_m, elat);
    check({tag, "_q"}, int'(quotient), eq);
    check({tag, "_r"}, int'(remainder), er);
    check({tag, "_dz"}, int'(div_by_zero), edz);
    check({tag, "_busy_cycles"}, busy_n, ebusy);
    check({tag, "_overlap"}, overlap, 0);
    @(negedge clk);
    check({tag, "_pulse"}, int'(done), 0);
    check({tag, "_q_hold"}, int'(quotient), eq);
  endtask

  initial begin
    int cnt;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_q", int'(quotient), 0);
    check("reset_r", int'(remainder), 0);
    check("reset_dz", int'(div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);

`ifndef SEQ_DIVIDER_SIGNED_EN
    run_op("d13_3", 4'd13, 4'd3, 4, 1, 0, 5, 4);
    run_op("d7_0", 4'd7, 4'd0, 15, 7, 1, 1, 0);
    run_op("d5_9", 4'd5, 4'd9, 0, 5, 0, 5, 4);
    run_op("d15_1", 4'd15, 4'd1, 15, 0, 0, 5, 4);

    // start held high; operands changed right after capture
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 4'd14;
    divisor  = 4'd4;
    repeat (5) @(negedge clk);
    check("held_done", int'(done), 1);
    check("held_busy_at_done", int'(busy), 0);
    check("held_q", int'(quotient), 4);
    check("held_r", int'(remainder), 1);
    @(negedge clk);
    check("held_restart_busy", int'(busy), 1);
    check("held_restart_done", int'(done), 0);
    start    = 1'b0;
    dividend = 4'd1;
    divisor  = 4'd1;
    repeat (5) @(negedge clk);
    check("held2_done", int'(done), 1);
    check("held2_q", int'(quotient), 3);
    check("held2_r", int'(remainder), 2);
    @(negedge clk);

    // reset asserted during the second RUN cycle
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_q", int'(quotient), 0);
    check("midrst_r", int'(remainder), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_dz", int'(div_by_zero), 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("midrst_no_done", cnt, 0);
    run_op("d12_4", 4'd12, 4'd4, 3, 0, 0, 5, 4);
`else
    run_op("sm7_2", 4'b1001, 4'd2, 13, 15, 0, 5, 4);
    run_op("s7_m2", 4'd7, 4'b1110, 13, 1, 0, 5, 4);
    run_op("sm8_m1", 4'b1000, 4'b1111, 8, 0, 0, 5, 4);
    run_op("sm6_0", 4'b1010, 4'd0, 15, 10, 1, 1, 0);
    run_op("s6_3", 4'd6, 4'd3, 2, 0, 0, 5, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
